// File: rtl/alu_sequencer.sv
// alu_sequencer: micro-sequencer for the 8-bit accumulator / B-register / ALU
// datapath. Takes one instruction at a time over a valid/ready handshake and
// expands it into a fixed sequence of registered datapath control words. It
// also captures the ALU carry/zero flags and returns accumulator reads.
//
// Ports:
//   clk, rst_n         clock (rising edge), synchronous active-low reset
//   instr_valid/ready  instruction handshake; ready is high only in IDLE
//   instr_op/imm       opcode (3b) and immediate (8b), latched on accept
//   bus_drv/_en        value the sequencer drives onto the datapath bus
//   nLa, nLb           active-low loads of accumulator / B register
//   Ea, Eu             accumulator / ALU bus drive enables
//   sub                ALU subtract select
//   acc_bus            datapath bus readback
//   cf_in, zf_in       ALU carry / zero flags from the datapath
//   flag_c, flag_z     captured flags
//   out_data/out_valid accumulator value returned by OUT, one-cycle pulse
//   done               one-cycle pulse when an instruction retires
//   illegal            one-cycle pulse (with done) for opcode 11x
module alu_sequencer #(
  parameter int unsigned FLAG_LAT = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       instr_valid,
  output logic       instr_ready,
  input  logic [2:0] instr_op,
  input  logic [7:0] instr_imm,
  output logic [7:0] bus_drv,
  output logic       bus_drv_en,
  output logic       nLa,
  output logic       nLb,
  output logic       Ea,
  output logic       Eu,
  output logic       sub,
  input  logic [7:0] acc_bus,
  input  logic       cf_in,
  input  logic       zf_in,
  output logic       flag_c,
  output logic       flag_z,
  output logic [7:0] out_data,
  output logic       out_valid,
  output logic       done,
  output logic       illegal
);

  localparam int unsigned OP_W   = 3;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = 3;

  localparam logic [OP_W-1:0] OP_NOP  = 3'b000;
  localparam logic [OP_W-1:0] OP_LDA  = 3'b001;
  localparam logic [OP_W-1:0] OP_ADD  = 3'b010;
  localparam logic [OP_W-1:0] OP_SUB  = 3'b011;
  localparam logic [OP_W-1:0] OP_OUT  = 3'b100;
  localparam logic [OP_W-1:0] OP_CLRF = 3'b101;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LDA   = 3'd1,
    S_LDB   = 3'd2,
    S_EXE   = 3'd3,
    S_WAITF = 3'd4,
    S_OUT   = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  state_t state;
  state_t next_state;

  logic [OP_W-1:0]  op_q;
  logic [CNT_W-1:0] cnt_q;
  logic             accept_c;
  logic             flag_sample_c;

  // Next-cycle values of the registered outputs
  logic              ready_d;
  logic [DATA_W-1:0] bus_drv_d;
  logic              bus_drv_en_d;
  logic              nla_d;
  logic              nlb_d;
  logic              ea_d;
  logic              eu_d;
  logic              sub_d;
  logic              out_valid_d;
  logic              done_d;
  logic              illegal_d;

  assign accept_c      = instr_valid & instr_ready;
  assign flag_sample_c = (state == S_WAITF) && (cnt_q == CNT_W'(1));

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: begin
        if (accept_c) begin
          case (instr_op)
            OP_LDA:         next_state = S_LDA;
            OP_ADD, OP_SUB: next_state = S_LDB;
            OP_OUT:         next_state = S_OUT;
            default:        next_state = S_DONE;
          endcase
        end
      end
      S_LDA:   next_state = S_DONE;
      S_LDB:   next_state = S_EXE;
      S_EXE:   next_state = S_WAITF;
      S_WAITF: if (flag_sample_c) next_state = S_DONE;
      S_OUT:   next_state = S_DONE;
      S_DONE:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // Output decode of the state about to be entered, so that every control
  // line is a flop that is valid for exactly the cycle spent in its state.
  always_comb begin
    ready_d      = 1'b0;
    bus_drv_d    = '0;
    bus_drv_en_d = 1'b0;
    nla_d        = 1'b1;
    nlb_d        = 1'b1;
    ea_d         = 1'b0;
    eu_d         = 1'b0;
    sub_d        = 1'b0;
    out_valid_d  = 1'b0;
    done_d       = 1'b0;
    illegal_d    = 1'b0;
    case (next_state)
      S_IDLE: ready_d = 1'b1;
      // S_LDA / S_LDB are entered only from IDLE on the accept edge, so the
      // immediate is taken straight from the instruction port.
      S_LDA: begin
        bus_drv_d    = instr_imm;
        bus_drv_en_d = 1'b1;
        nla_d        = 1'b0;
      end
      S_LDB: begin
        bus_drv_d    = instr_imm;
        bus_drv_en_d = 1'b1;
        nlb_d        = 1'b0;
      end
      S_EXE: begin
        eu_d  = 1'b1;
        nla_d = 1'b0;
        sub_d = (op_q == OP_SUB);
      end
      S_OUT: ea_d = 1'b1;
      S_DONE: begin
        done_d      = 1'b1;
        out_valid_d = (state == S_OUT);
        illegal_d   = (state == S_IDLE) && (instr_op[2:1] == 2'b11);
      end
      default: ;
    endcase
  end

  // Registered outputs, latched opcode, flag wait counter and captures
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      instr_ready <= 1'b1;
      bus_drv     <= '0;
      bus_drv_en  <= 1'b0;
      nLa         <= 1'b1;
      nLb         <= 1'b1;
      Ea          <= 1'b0;
      Eu          <= 1'b0;
      sub         <= 1'b0;
      out_valid   <= 1'b0;
      done        <= 1'b0;
      illegal     <= 1'b0;
      flag_c      <= 1'b0;
      flag_z      <= 1'b0;
      out_data    <= '0;
      op_q        <= OP_NOP;
      cnt_q       <= '0;
    end else begin
      instr_ready <= ready_d;
      bus_drv     <= bus_drv_d;
      bus_drv_en  <= bus_drv_en_d;
      nLa         <= nla_d;
      nLb         <= nlb_d;
      Ea          <= ea_d;
      Eu          <= eu_d;
      sub         <= sub_d;
      out_valid   <= out_valid_d;
      done        <= done_d;
      illegal     <= illegal_d;

      if (accept_c) begin
        op_q <= instr_op;
      end

      // Counter holds FLAG_LAT on the first WAITF cycle; flags are sampled
      // in the WAITF cycle where it reads 1.
      if (state == S_EXE) begin
        cnt_q <= CNT_W'(FLAG_LAT);
      end else if (state == S_WAITF) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end

      if (flag_sample_c) begin
        flag_c <= cf_in;
        flag_z <= zf_in;
      end else if (accept_c && (instr_op == OP_CLRF)) begin
        flag_c <= 1'b0;
        flag_z <= 1'b0;
      end

      if (state == S_OUT) begin
        out_data <= acc_bus;
      end
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: two instances (FLAG_LAT=1 and FLAG_LAT=4), each
// attached to a small accumulator/B/ALU datapath model. Expected results are
// queued when an instruction is accepted and compared when done pulses.
module tb_alu_sequencer;

  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_LDA  = 3'd1;
  localparam logic [2:0] OP_ADD  = 3'd2;
  localparam logic [2:0] OP_SUB  = 3'd3;
  localparam logic [2:0] OP_OUT  = 3'd4;
  localparam logic [2:0] OP_CLRF = 3'd5;
  localparam logic [2:0] OP_ILL6 = 3'd6;
  localparam logic [2:0] OP_ILL7 = 3'd7;
  localparam int FLAT0 = 1;
  localparam int FLAT1 = 4;

  typedef struct {
    int         d;
    logic [2:0] op;
    logic [7:0] imm;
    logic [7:0] out;
    logic       cf;
    logic       zf;
    logic       ill;
    int         lat;
    int         nla, nlb, ea, eu, sb, drv;
    longint     t_acc;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       instr_valid [2];
  logic       instr_ready [2];
  logic [2:0] instr_op    [2];
  logic [7:0] instr_imm   [2];
  logic [7:0] bus_drv     [2];
  logic       bus_drv_en  [2];
  logic       nLa [2];
  logic       nLb [2];
  logic       Ea  [2];
  logic       Eu  [2];
  logic       sub [2];
  logic [7:0] acc_bus  [2];
  logic       cf_in    [2];
  logic       zf_in    [2];
  logic       flag_c   [2];
  logic       flag_z   [2];
  logic [7:0] out_data [2];
  logic       out_valid[2];
  logic       done     [2];
  logic       illegal  [2];

  logic [7:0] dp_a  [2] = '{8'h00, 8'h00};
  logic [7:0] dp_b  [2] = '{8'h00, 8'h00};
  logic       dp_cf [2] = '{1'b0, 1'b0};
  logic       dp_zf [2] = '{1'b0, 1'b0};
  logic [8:0] alu_r [2];

  logic [7:0] ref_a  [2] = '{8'h00, 8'h00};
  logic       ref_cf [2] = '{1'b0, 1'b0};
  logic       ref_zf [2] = '{1'b0, 1'b0};

  int c_nla[2] = '{0, 0};
  int c_nlb[2] = '{0, 0};
  int c_ea [2] = '{0, 0};
  int c_eu [2] = '{0, 0};
  int c_sb [2] = '{0, 0};
  int c_drv[2] = '{0, 0};

  exp_t sbq[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  logic mon_en   = 1'b0;

  alu_sequencer #(.FLAG_LAT(FLAT0)) u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .instr_valid(instr_valid[0]), .instr_ready(instr_ready[0]),
    .instr_op(instr_op[0]), .instr_imm(instr_imm[0]),
    .bus_drv(bus_drv[0]), .bus_drv_en(bus_drv_en[0]),
    .nLa(nLa[0]), .nLb(nLb[0]), .Ea(Ea[0]), .Eu(Eu[0]), .sub(sub[0]),
    .acc_bus(acc_bus[0]), .cf_in(cf_in[0]), .zf_in(zf_in[0]),
    .flag_c(flag_c[0]), .flag_z(flag_z[0]),
    .out_data(out_data[0]), .out_valid(out_valid[0]),
    .done(done[0]), .illegal(illegal[0])
  );

  alu_sequencer #(.FLAG_LAT(FLAT1)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .instr_valid(instr_valid[1]), .instr_ready(instr_ready[1]),
    .instr_op(instr_op[1]), .instr_imm(instr_imm[1]),
    .bus_drv(bus_drv[1]), .bus_drv_en(bus_drv_en[1]),
    .nLa(nLa[1]), .nLb(nLb[1]), .Ea(Ea[1]), .Eu(Eu[1]), .sub(sub[1]),
    .acc_bus(acc_bus[1]), .cf_in(cf_in[1]), .zf_in(zf_in[1]),
    .flag_c(flag_c[1]), .flag_z(flag_z[1]),
    .out_data(out_data[1]), .out_valid(out_valid[1]),
    .done(done[1]), .illegal(illegal[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [8:0] alu9(input logic [7:0] a, input logic [7:0] b,
                                      input logic s);
    if (s) alu9 = {1'b0, a} + {1'b0, ~b} + 9'd1;
    else   alu9 = {1'b0, a} + {1'b0, b};
  endfunction

  // Datapath model: bus mux, A/B registers, flags latched on the execute edge
  always_comb begin
    for (int g = 0; g < 2; g++) begin
      alu_r[g] = alu9(dp_a[g], dp_b[g], sub[g]);
      if (bus_drv_en[g])  acc_bus[g] = bus_drv[g];
      else if (Ea[g])     acc_bus[g] = dp_a[g];
      else if (Eu[g])     acc_bus[g] = alu_r[g][7:0];
      else                acc_bus[g] = 8'h00;
      cf_in[g] = dp_cf[g];
      zf_in[g] = dp_zf[g];
    end
  end

  always @(posedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (nLa[g] === 1'b0) dp_a[g] <= acc_bus[g];
      if (nLb[g] === 1'b0) dp_b[g] <= acc_bus[g];
      if (Eu[g] === 1'b1) begin
        dp_cf[g] <= alu_r[g][8];
        dp_zf[g] <= (alu_r[g][7:0] == 8'h00);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int find(input int d);
    for (int i = 0; i < sbq.size(); i++) if (sbq[i].d == d) return i;
    return -1;
  endfunction

  function automatic int pending(input int d);
    int n = 0;
    for (int i = 0; i < sbq.size(); i++) if (sbq[i].d == d) n++;
    return n;
  endfunction

  task automatic clear_counts(input int d);
    c_nla[d] = 0; c_nlb[d] = 0; c_ea[d] = 0;
    c_eu[d]  = 0; c_sb[d]  = 0; c_drv[d] = 0;
  endtask

  // Per-cycle monitor for one instance
  task automatic mon_step(input int d);
    int     idx;
    exp_t   e;
    longint lat;
    string  p;
    p = $sformatf("d%0d_", d);
    if (!rst_n) begin
      clear_counts(d);
      for (int i = sbq.size() - 1; i >= 0; i--) if (sbq[i].d == d) sbq.delete(i);
      return;
    end
    check({p, "excl"}, 32'({($countones({bus_drv_en[d], Ea[d], Eu[d]}) <= 1),
                            ($countones({~nLa[d], ~nLb[d]}) <= 1)}), 32'd3);
    c_nla[d] += int'(!nLa[d]);
    c_nlb[d] += int'(!nLb[d]);
    c_ea[d]  += int'(Ea[d]);
    c_eu[d]  += int'(Eu[d]);
    c_sb[d]  += int'(sub[d]);
    c_drv[d] += int'(bus_drv_en[d]);
    idx = find(d);
    if (idx >= 0) begin
      check({p, "busy_ready"}, 32'(instr_ready[d]), 32'd0);
      if (bus_drv_en[d]) check({p, "bus_drv"}, 32'(bus_drv[d]), 32'(sbq[idx].imm));
    end
    if (done[d]) begin
      if (idx < 0) begin
        check({p, "spurious_done"}, 32'(done[d]), 32'd0);
      end else begin
        e = sbq[idx];
        sbq.delete(idx);
        lat = ($time - 64'd5 - e.t_acc) / 10 + 1;
        check({p, "latency"}, 32'(lat), 32'(e.lat));
        check({p, "illegal"}, 32'(illegal[d]), 32'(e.ill));
        check({p, "out_valid"}, 32'(out_valid[d]), 32'(e.op == OP_OUT));
        if (e.op == OP_OUT) check({p, "out_data"}, 32'(out_data[d]), 32'(e.out));
        check({p, "flags"}, 32'({flag_c[d], flag_z[d]}), 32'({e.cf, e.zf}));
        check({p, "ctl_cycles"},
              32'({4'(c_nla[d]), 4'(c_nlb[d]), 4'(c_ea[d]), 4'(c_eu[d]), 4'(c_sb[d]), 4'(c_drv[d])}),
              32'({4'(e.nla), 4'(e.nlb), 4'(e.ea), 4'(e.eu), 4'(e.sb), 4'(e.drv)}));
        clear_counts(d);
      end
    end else if (illegal[d] || out_valid[d]) begin
      check({p, "stray_pulse"}, 32'({illegal[d], out_valid[d]}), 32'd0);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      for (int d = 0; d < 2; d++) mon_step(d);
    end
  end

  // Offer one instruction, wait for the transfer, queue its expected outcome
  task automatic issue(input int d, input logic [2:0] op, input logic [7:0] imm,
                       input bit hold);
    exp_t     e;
    logic     r;
    logic     got;
    logic [8:0] res;
    @(negedge clk);
    instr_valid[d] = 1'b1;
    instr_op[d]    = op;
    instr_imm[d]   = imm;
    got = 1'b0;
    for (int t = 0; t < 64; t++) begin
      r = instr_ready[d];
      @(posedge clk);
      if (r === 1'b1) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!got) begin
      check($sformatf("d%0d_accept_timeout", d), 32'(got), 32'd1);
      instr_valid[d] = 1'b0;
      return;
    end
    e = '{d: d, op: op, imm: imm, out: 8'h00, cf: 1'b0, zf: 1'b0, ill: 1'b0,
          lat: 1, nla: 0, nlb: 0, ea: 0, eu: 0, sb: 0, drv: 0, t_acc: $time};
    case (op)
      OP_NOP: e.lat = 1;
      OP_LDA: begin
        ref_a[d] = imm;
        e.lat = 2; e.nla = 1; e.drv = 1;
      end
      OP_ADD, OP_SUB: begin
        res = alu9(ref_a[d], imm, op == OP_SUB);
        ref_a[d]  = res[7:0];
        ref_cf[d] = res[8];
        ref_zf[d] = (res[7:0] == 8'h00);
        e.lat = 3 + ((d == 0) ? FLAT0 : FLAT1);
        e.nla = 1; e.nlb = 1; e.eu = 1; e.drv = 1; e.sb = (op == OP_SUB) ? 1 : 0;
      end
      OP_OUT: begin
        e.out = ref_a[d];
        e.lat = 2; e.ea = 1;
      end
      OP_CLRF: begin
        ref_cf[d] = 1'b0;
        ref_zf[d] = 1'b0;
        e.lat = 1;
      end
      default: begin
        e.ill = 1'b1;
        e.lat = 1;
      end
    endcase
    e.cf = ref_cf[d];
    e.zf = ref_zf[d];
    sbq.push_back(e);
    if (!hold) begin
      @(negedge clk);
      instr_valid[d] = 1'b0;
    end
  endtask

  task automatic wait_idle(input int d);
    for (int t = 0; t < 100; t++) begin
      if (pending(d) == 0) return;
      @(negedge clk);
    end
    check($sformatf("d%0d_drain_timeout", d), 32'(pending(d)), 32'd0);
  endtask

  task automatic check_defaults(input int d, input string tag);
    string p;
    p = $sformatf("%s%0d_", tag, d);
    check({p, "ctl"}, 32'({nLa[d], nLb[d], Ea[d], Eu[d], sub[d], bus_drv_en[d]}), 32'b110000);
    check({p, "bus_drv"}, 32'(bus_drv[d]), 32'd0);
    check({p, "flags"}, 32'({flag_c[d], flag_z[d]}), 32'd0);
    check({p, "out_data"}, 32'(out_data[d]), 32'd0);
    check({p, "pulses"}, 32'({out_valid[d], done[d], illegal[d]}), 32'd0);
    check({p, "ready"}, 32'(instr_ready[d]), 32'd1);
  endtask

  initial begin
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      instr_valid[d] = 1'b0;
      instr_op[d]    = OP_NOP;
      instr_imm[d]   = 8'h00;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_defaults(0, "rst");
    check_defaults(1, "rst");
    mon_en = 1'b1;

    // Load and read back
    issue(0, OP_LDA, 8'h5A, 1'b0);
    issue(0, OP_OUT, 8'h00, 1'b0);
    wait_idle(0);

    // Add with carry out
    issue(0, OP_LDA, 8'hF0, 1'b0);
    issue(0, OP_ADD, 8'h20, 1'b0);
    wait_idle(0);

    // Subtract to zero, read back, clear flags
    issue(0, OP_LDA, 8'h07, 1'b0);
    issue(0, OP_SUB, 8'h07, 1'b0);
    issue(0, OP_OUT, 8'h00, 1'b0);
    issue(0, OP_CLRF, 8'h00, 1'b0);
    wait_idle(0);

    // Illegal opcodes leave nonzero flags alone
    issue(0, OP_LDA, 8'h80, 1'b0);
    issue(0, OP_ADD, 8'h80, 1'b0);
    issue(0, OP_ILL6, 8'h33, 1'b0);
    issue(0, OP_ILL7, 8'h44, 1'b0);
    wait_idle(0);

    // Back-to-back with instr_valid held high
    issue(0, OP_LDA, 8'h3C, 1'b1);
    issue(0, OP_ADD, 8'h11, 1'b1);
    issue(0, OP_OUT, 8'h00, 1'b1);
    issue(0, OP_SUB, 8'h4D, 1'b1);
    issue(0, OP_NOP, 8'h00, 1'b0);
    wait_idle(0);

    // Random stream, mostly back-to-back
    for (int i = 0; i < 24; i++) begin
      issue(0, 3'($urandom_range(0, 7)), 8'($urandom), (i != 23) && ($urandom_range(0, 3) != 0));
    end
    wait_idle(0);

    // Longer flag latency instance
    issue(1, OP_LDA, 8'hFF, 1'b0);
    issue(1, OP_ADD, 8'h01, 1'b0);
    issue(1, OP_OUT, 8'h00, 1'b0);
    issue(1, OP_SUB, 8'h01, 1'b0);
    wait_idle(1);

    // Reset in the middle of an ADD execute cycle
    issue(0, OP_LDA, 8'h01, 1'b0);
    issue(0, OP_ADD, 8'h02, 1'b0);
    for (int t = 0; t < 20 && Eu[0] !== 1'b1; t++) @(negedge clk);
    check("d0_mid_eu", 32'(Eu[0]), 32'd1);
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      ref_cf[d] = 1'b0;
      ref_zf[d] = 1'b0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_defaults(0, "midrst");
    check_defaults(1, "midrst");

    // Normal operation resumes after reset
    issue(0, OP_LDA, 8'h22, 1'b0);
    issue(0, OP_OUT, 8'h00, 1'b0);
    issue(0, OP_ADD, 8'hDE, 1'b0);
    wait_idle(0);
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_checks);
    $fatal(1, "simulation timeout");
  end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
Micro-sequencer that drives the 8-bit accumulator/B-register/ALU datapath from a simple instruction stream. Accepts one instruction at a time over a valid/ready handshake. Expands each instruction into a fixed sequence of datapath control words (nLa, nLb, Ea, Eu, sub, bus drive), captures the ALU carry/zero flags, and returns accumulator reads. Sits between the host pins and the datapath, replacing direct pin control of the load/enable lines.

Parameters:
FLAG_LAT, 1, cycles after the ALU-execute cycle before cf_in/zf_in are sampled (legal 1..4).

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  synchronous active-low reset
instr_valid  input  1  instruction offered
instr_ready  output  1  sequencer can accept an instruction
instr_op  input  3  opcode
instr_imm  input  8  immediate operand
bus_drv  output  8  value the sequencer places on the datapath bus
bus_drv_en  output  1  sequencer owns the bus this cycle
nLa  output  1  active-low load of accumulator from bus
nLb  output  1  active-low load of B register from bus
Ea  output  1  accumulator drives bus
Eu  output  1  ALU drives bus
sub  output  1  ALU subtract select
acc_bus  input  8  datapath bus readback
cf_in  input  1  ALU carry flag
zf_in  input  1  ALU zero flag
flag_c  output  1  captured carry
flag_z  output  1  captured zero
out_data  output  8  last accumulator value read by OUT
out_valid  output  1  one-cycle pulse, out_data updated
done  output  1  one-cycle pulse, instruction retired
illegal  output  1  one-cycle pulse, opcode 11x received

Behaviour:
- Reset (rst_n=0 at a clock edge): state IDLE; nLa=nLb=1; Ea=Eu=sub=bus_drv_en=0; bus_drv=0; flag_c=flag_z=0; out_data=0; out_valid=done=illegal=0; instr_ready=1 in the cycle after reset. Reset mid-instruction abandons it with no done pulse; datapath registers are not touched.
- Opcodes: 000 NOP, 001 LDA, 010 ADD, 011 SUB, 100 OUT, 101 CLRF, 11x illegal.
- Handshake: instr_ready=1 only in IDLE. Transfer occurs on an edge where instr_valid & instr_ready; op/imm are latched at that edge. instr_imm may change afterwards.
- All control outputs are registered per state. Defaults in every state: nLa=nLb=1, Ea=Eu=sub=bus_drv_en=0.
- States:
  - IDLE: on accept, go to S_LDA, S_LDB, S_OUT, or S_DONE (for NOP, CLRF, illegal).
  - S_LDA: bus_drv=imm, bus_drv_en=1, nLa=0. Next state S_DONE.
  - S_LDB: bus_drv=imm, bus_drv_en=1, nLb=0. Next state S_EXE.
  - S_EXE: Eu=1, nLa=0, sub=(op==SUB), bus_drv_en=0. Next state S_WAITF; wait counter loads FLAG_LAT.
  - S_WAITF: counter decrements each cycle. In the cycle it reaches 1, flag_c<=cf_in and flag_z<=zf_in, then S_DONE.
  - S_OUT: Ea=1. out_data<=acc_bus at the end of this cycle. Next state S_DONE, with out_valid=1 in S_DONE.
  - S_DONE: done=1 for one cycle, then IDLE. CLRF clears flag_c and flag_z on entry to S_DONE. Illegal opcodes pulse illegal=1 together with done and leave flags unchanged.
- Latencies, accept edge to done cycle:
  - NOP, CLRF, illegal: 1 cycle.
  - LDA, OUT: 2 cycles.
  - ADD, SUB: 3+FLAG_LAT cycles.
- Invariants, every cycle: at most one of {bus_drv_en, Ea, Eu} is high; at most one of {nLa, nLb} is low.
- Flags hold between ADD/SUB instructions. LDA and OUT do not alter flags.
- Arithmetic is performed by the datapath (8-bit modulo 256). The sequencer never computes results.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles while Eu=1 mid-ADD -> next cycle all controls at defaults, flags=0, instr_ready=1, no done pulse.
- LDA 0x5A, then OUT -> nLa=0 with bus_drv=0x5A for exactly one cycle; then Ea=1 for one cycle; out_data=0x5A with out_valid pulse.
- LDA 0xF0, ADD 0x20 (FLAG_LAT=1) -> nLb=0 with bus=0x20, then Eu=1/nLa=0/sub=0; model gives A=0x10 and CF=1; flag_c=1, flag_z=0; done 4 cycles after accept.
- LDA 0x07, SUB 0x07 -> sub=1 during S_EXE; flag_z=1; OUT returns 0x00. Then CLRF -> flag_c=flag_z=0 one cycle later.
- Back-to-back: instr_valid held high with 5 queued instructions -> instr_ready low throughout each sequence; each instruction accepted exactly once; control-exclusivity invariants hold every cycle.
- Opcode 110 -> illegal and done pulse in the same cycle; no control line asserted; flags unchanged; FLAG_LAT=4 run of ADD -> done at accept+7.
